// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit seven-segment driver: hex decode, blanking, decimal points,
// leading-zero suppression, PWM brightness and frame-synchronous capture of display inputs.
module seven_seg_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BRIGHT_W    = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [4*NUM_DIGITS-1:0]         value,
  input  logic [NUM_DIGITS-1:0]           dp_in,
  input  logic [NUM_DIGITS-1:0]           blank,
  input  logic                            lz_suppress,
  input  logic [BRIGHT_W-1:0]             brightness,
  output logic [6:0]                      seg,
  output logic                            dp_n,
  output logic [NUM_DIGITS-1:0]           anode,
  output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx,
  output logic                            frame_tick
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  logic [PW-1:0]           presc;
  logic [BRIGHT_W-1:0]     pwm_cnt;
  logic [4*NUM_DIGITS-1:0] sh_val;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blank;
  logic                    load_pending;

  logic                    slot_end;
  logic                    frame_end;
  logic                    lit;
  logic [3:0]              nib;
  logic [NUM_DIGITS-1:0]   lz_dark;

  // Segment pattern returned with seg[0]=a .. seg[6]=g, active-low.
  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] abcdefg;
    logic [6:0] r;
    case (n)
      4'h0: abcdefg = 7'b0000001;
      4'h1: abcdefg = 7'b1001111;
      4'h2: abcdefg = 7'b0010010;
      4'h3: abcdefg = 7'b0000110;
      4'h4: abcdefg = 7'b1001100;
      4'h5: abcdefg = 7'b0100100;
      4'h6: abcdefg = 7'b0100000;
      4'h7: abcdefg = 7'b0001111;
      4'h8: abcdefg = 7'b0000000;
      4'h9: abcdefg = 7'b0000100;
      4'hA: abcdefg = 7'b0001000;
      4'hB: abcdefg = 7'b1100000;
      4'hC: abcdefg = 7'b0110001;
      4'hD: abcdefg = 7'b1000010;
      4'hE: abcdefg = 7'b0110000;
      default: abcdefg = 7'b0111000;
    endcase
    for (int unsigned b = 0; b < 7; b++) r[b] = abcdefg[6-b];
    return r;
  endfunction

  always_comb begin
    logic zero_run;
    zero_run  = 1'b1;
    lz_dark   = '0;
    slot_end  = (presc == PW'(REFRESH_DIV - 1));
    frame_end = slot_end && (digit_idx == IW'(NUM_DIGITS - 1));
    nib       = sh_val[4*digit_idx +: 4];
    // Walk from the most significant digit down; a digit is suppressed while every nibble
    // from it upward is zero. Digit 0 always shows.
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      zero_run = zero_run && (sh_val[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
      lz_dark[NUM_DIGITS-1-k] = lz_suppress && zero_run && (k != NUM_DIGITS - 1);
    end
    lit = en && !load_pending && !sh_blank[digit_idx] && !lz_dark[digit_idx]
          && (pwm_cnt <= brightness);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc        <= '0;
      digit_idx    <= '0;
      pwm_cnt      <= '0;
      sh_val       <= '0;
      sh_dp        <= '0;
      sh_blank     <= '0;
      load_pending <= 1'b1;
      anode        <= '1;
      seg          <= '1;
      dp_n         <= 1'b1;
      frame_tick   <= 1'b0;
    end else begin
      pwm_cnt      <= pwm_cnt + 1'b1;
      load_pending <= 1'b0;
      frame_tick   <= en && frame_end;

      if (!en) begin
        presc     <= '0;
        digit_idx <= '0;
      end else if (slot_end) begin
        presc     <= '0;
        digit_idx <= frame_end ? '0 : digit_idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end

      if (!en || frame_end || load_pending) begin
        sh_val   <= value;
        sh_dp    <= dp_in;
        sh_blank <= blank;
      end

      if (lit) begin
        anode <= ~(NUM_DIGITS'(1) << digit_idx);
        seg   <= decode(nib);
        dp_n  <= ~sh_dp[digit_idx];
      end else begin
        anode <= '1;
        seg   <= '1;
        dp_n  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomized self-checking bench for seven_seg_scanner against a slot-arithmetic reference model.
module tb_seven_seg_scanner;

  localparam int N    = 4;
  localparam int RD   = 4;
  localparam int BW   = 4;
  localparam int IW   = $clog2(N);
  localparam int VW   = 4 * N;
  localparam int NCYC = 4000;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [VW-1:0] value;
  logic [N-1:0]  dp_in;
  logic [N-1:0]  blank;
  logic          lz_suppress;
  logic [BW-1:0] brightness;
  logic [6:0]    seg;
  logic          dp_n;
  logic [N-1:0]  anode;
  logic [IW-1:0] digit_idx;
  logic          frame_tick;

  int checks = 0;
  int errors = 0;

  seven_seg_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BRIGHT_W(BW)) dut (
    .clk(clk), .rst(rst), .en(en), .value(value), .dp_in(dp_in), .blank(blank),
    .lz_suppress(lz_suppress), .brightness(brightness), .seg(seg), .dp_n(dp_n),
    .anode(anode), .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Glyphs written a..g left to right (a is the leftmost character).
  logic [6:0] font [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // Reference state: t counts enabled cycles within the current frame.
  int            t;
  int            pwm;
  logic [VW-1:0] sh_val;
  logic [N-1:0]  sh_dp, sh_bl;
  bit            pending;
  logic [N-1:0]  exp_anode;
  logic [6:0]    exp_seg;
  logic          exp_dp, exp_ft;
  int            exp_idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input int n);
    logic [6:0] g, r;
    g = font[n];
    for (int b = 0; b < 7; b++) r[b] = g[6-b];
    return r;
  endfunction

  task automatic model_edge();
    int  idx;
    bit  frame_end, lzd, lit;
    if (rst) begin
      t = 0; pwm = 0; sh_val = '0; sh_dp = '0; sh_bl = '0; pending = 1;
      exp_anode = '1; exp_seg = '1; exp_dp = 1; exp_ft = 0; exp_idx = 0;
      return;
    end
    idx       = t / RD;
    frame_end = (t == RD * N - 1);
    lzd       = (idx >= 1) && ((sh_val >> (4 * idx)) == 0) && lz_suppress;
    lit       = en && !pending && !sh_bl[idx] && !lzd && (pwm <= int'(brightness));
    if (lit) begin
      exp_anode = '1;
      exp_anode[idx] = 1'b0;
      exp_seg = glyph(int'((sh_val >> (4 * idx)) & 'hF));
      exp_dp  = !sh_dp[idx];
    end else begin
      exp_anode = '1; exp_seg = '1; exp_dp = 1;
    end
    exp_ft = en && frame_end;
    if (!en || frame_end || pending) begin
      sh_val = value; sh_dp = dp_in; sh_bl = blank;
    end
    pending = 0;
    t       = en ? (t + 1) % (RD * N) : 0;
    exp_idx = t / RD;
    pwm     = (pwm + 1) % (1 << BW);
  endtask

  function automatic logic [VW-1:0] pick_value();
    logic [VW-1:0] v;
    v = VW'($urandom);
    case ($urandom_range(0, 5))
      0: return v;
      1: return v >> (4 * $urandom_range(1, N - 1));
      2: return VW'(16'h0050);
      3: return '0;
      4: return VW'(16'h1234);
      default: return VW'(16'hABCD);
    endcase
  endfunction

  initial begin
    int en_off;
    int phase;
    en_off = 0;
    rst = 1; en = 1; value = VW'(16'h1234); dp_in = '0; blank = '0;
    lz_suppress = 0; brightness = '1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (cyc > 0) begin
        check("anode", 32'(anode), 32'(exp_anode));
        check("seg", 32'(seg), 32'(exp_seg));
        check("dp_n", 32'(dp_n), 32'(exp_dp));
        check("digit_idx", 32'(digit_idx), 32'(exp_idx));
        check("frame_tick", 32'(frame_tick), 32'(exp_ft));
        check("anode_onehot", 32'($countones(~anode) <= 1), 32'(1));
      end
      phase = cyc / 500;
      rst   = (cyc < 2) || ($urandom_range(0, 399) == 0);
      if (cyc % 500 == 0) begin
        brightness  = (phase < 2) ? '1 : BW'($urandom);
        lz_suppress = phase[0];
      end
      if (en_off > 0) begin
        en = 0; en_off--;
      end else begin
        en = 1;
        if (phase > 0 && $urandom_range(0, 149) == 0) en_off = $urandom_range(1, 6);
      end
      if ($urandom_range(0, 29) == 0) value = pick_value();
      if ($urandom_range(0, 29) == 0) dp_in = N'($urandom);
      if ($urandom_range(0, 39) == 0) blank = (phase >= 4) ? N'($urandom & $urandom) : '0;
      model_edge();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
